board_lock_clear: RTL and testbench

//  Downstream of the falling-piece controller. On a touch pulse it locks the four active cells

---
 rtl/board_lock_clear.sv | 171 +++++++++++++++++
 tb/tb_board_lock_clear.sv | 252 +++++++++++++++++++++++++
 2 files changed

// File: rtl/board_lock_clear.sv
// Playfield owner: locks a landed piece, removes full rows bottom-up,
// scores the clear and signals the next spawn.
module board_lock_clear #(
  parameter int ROWS = 20,
  parameter int COLS = 10
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 clear_board,
  input  logic                 touch,
  input  logic [7:0]           blk0,
  input  logic [7:0]           blk1,
  input  logic [7:0]           blk2,
  input  logic [7:0]           blk3,
  output logic [ROWS*COLS-1:0] occupied,
  output logic                 del_to_dro,
  output logic                 busy,
  output logic [2:0]           lines_cleared,
  output logic [15:0]          score,
  output logic                 game_over
);

  localparam int NCELLS = ROWS * COLS;
  localparam int RW = $clog2(ROWS);
  localparam logic [RW-1:0] LAST_ROW = RW'(ROWS - 1);
  localparam logic [8:0] NCELLS9 = 9'(NCELLS);

  typedef enum logic [1:0] {
    S_IDLE,
    S_SCAN,
    S_DONE,
    S_OVER
  } state_t;

  state_t state_q, state_d;

  logic [COLS-1:0] rows_q [ROWS];
  logic [COLS-1:0] rows_d [ROWS];
  logic [COLS-1:0] lock_rows [ROWS];
  logic [COLS-1:0] shift_rows [ROWS];

  logic [NCELLS-1:0] occ_flat;
  logic [NCELLS-1:0] lock_flat;

  logic [RW-1:0] row_ptr_q, row_ptr_d;
  logic [2:0]    cnt_q, cnt_d;
  logic          del_q, del_d;
  logic          busy_q, busy_d;
  logic [2:0]    lines_q, lines_d;
  logic [15:0]   score_q, score_d;
  logic          over_q, over_d;

  logic          row_full;
  logic          spawn_hit;
  logic [15:0]   pts;
  logic [16:0]   score_sum;
  logic [15:0]   score_sat;

  // Row r of the map is the flat slice starting at COLS*r, col c at bit c.
  for (genvar g = 0; g < ROWS; g++) begin : g_rows
    assign occ_flat[g*COLS +: COLS] = rows_q[g];
    assign lock_rows[g] = lock_flat[g*COLS +: COLS];
    if (g == 0) begin : g_top
      assign shift_rows[g] = '0;
    end else begin : g_below
      assign shift_rows[g] = (RW'(g) <= row_ptr_q) ?
                             rows_q[g-1] : rows_q[g];
    end
  end

  always_comb begin
    lock_flat = occ_flat;
    if ({1'b0, blk0} < NCELLS9) lock_flat[blk0] = 1'b1;
    if ({1'b0, blk1} < NCELLS9) lock_flat[blk1] = 1'b1;
    if ({1'b0, blk2} < NCELLS9) lock_flat[blk2] = 1'b1;
    if ({1'b0, blk3} < NCELLS9) lock_flat[blk3] = 1'b1;
  end

  assign row_full  = &rows_q[row_ptr_q];
  assign spawn_hit = |rows_q[0][6:3];

  always_comb begin
    pts = 16'd0;
    unique case (cnt_q)
      3'd1:    pts = 16'd100;
      3'd2:    pts = 16'd300;
      3'd3:    pts = 16'd500;
      3'd4:    pts = 16'd800;
      default: pts = 16'd0;
    endcase
  end

  assign score_sum = {1'b0, score_q} + {1'b0, pts};
  assign score_sat = score_sum[16] ? 16'hFFFF : score_sum[15:0];

  always_comb begin
    state_d   = state_q;
    rows_d    = rows_q;
    row_ptr_d = row_ptr_q;
    cnt_d     = cnt_q;
    lines_d   = lines_q;
    score_d   = score_q;
    unique case (state_q)
      S_IDLE: begin
        if (touch) begin
          rows_d    = lock_rows;
          row_ptr_d = LAST_ROW;
          cnt_d     = 3'd0;
          state_d   = S_SCAN;
        end
      end
      S_SCAN: begin
        // A removed row pulls the next one down, so stay on it.
        if (row_full) begin
          rows_d = shift_rows;
          cnt_d  = cnt_q + 3'd1;
        end else if (row_ptr_q == '0) begin
          state_d = S_DONE;
        end else begin
          row_ptr_d = row_ptr_q - RW'(1);
        end
      end
      S_DONE: begin
        lines_d = cnt_q;
        score_d = score_sat;
        state_d = spawn_hit ? S_OVER : S_IDLE;
      end
      S_OVER: begin
        state_d = S_OVER;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
    del_d  = (state_d == S_DONE);
    busy_d = (state_d == S_SCAN) || (state_d == S_DONE);
    over_d = (state_d == S_OVER);
  end

  always_ff @(posedge clk) begin
    if (rst || clear_board) begin
      state_q   <= S_IDLE;
      rows_q    <= '{default: '0};
      row_ptr_q <= '0;
      cnt_q     <= 3'd0;
      del_q     <= 1'b0;
      busy_q    <= 1'b0;
      lines_q   <= 3'd0;
      score_q   <= 16'd0;
      over_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      rows_q    <= rows_d;
      row_ptr_q <= row_ptr_d;
      cnt_q     <= cnt_d;
      del_q     <= del_d;
      busy_q    <= busy_d;
      lines_q   <= lines_d;
      score_q   <= score_d;
      over_q    <= over_d;
    end
  end

  assign occupied      = occ_flat;
  assign del_to_dro    = del_q;
  assign busy          = busy_q;
  assign lines_cleared = lines_q;
  assign score         = score_q;
  assign game_over     = over_q;

endmodule

// File: tb/tb_board_lock_clear.sv
// Bench for board_lock_clear: directed scenarios then random locks,
// checked against a row-list model of the playfield.
module tb_board_lock_clear;

  localparam int ROWS = 20;
  localparam int COLS = 10;
  localparam int NC = ROWS * COLS;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          clear_board = 1'b0;
  logic          touch = 1'b0;
  logic [7:0]    blk0 = '0, blk1 = '0, blk2 = '0, blk3 = '0;
  logic [NC-1:0] occupied;
  logic          del_to_dro, busy, game_over;
  logic [2:0]    lines_cleared;
  logic [15:0]   score;

  int n_asrt = 0;
  int n_fail = 0;

  int grid [ROWS][COLS];
  int m_score;
  bit m_over;

  board_lock_clear #(.ROWS(ROWS), .COLS(COLS)) dut (
    .clk(clk), .rst(rst), .clear_board(clear_board), .touch(touch),
    .blk0(blk0), .blk1(blk1), .blk2(blk2), .blk3(blk3),
    .occupied(occupied), .del_to_dro(del_to_dro), .busy(busy),
    .lines_cleared(lines_cleared), .score(score), .game_over(game_over)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [NC-1:0] obs,
                     input logic [NC-1:0] exp);
    n_asrt++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic m_reset();
    foreach (grid[r, c]) grid[r][c] = 0;
    m_score = 0;
    m_over = 0;
  endtask

  function automatic logic [NC-1:0] m_flat();
    logic [NC-1:0] v = '0;
    foreach (grid[r, c]) if (grid[r][c] != 0) v[r*COLS+c] = 1'b1;
    return v;
  endfunction

  // Lock cells, drop every full row, compact survivors to the bottom.
  task automatic m_lock(input int b[4], output int k);
    int ng [ROWS][COLS];
    int dst;
    int pts [5] = '{0, 100, 300, 500, 800};
    k = 0;
    foreach (b[i]) if (b[i] < NC) grid[b[i] / COLS][b[i] % COLS] = 1;
    foreach (ng[r, c]) ng[r][c] = 0;
    dst = ROWS - 1;
    for (int r = ROWS - 1; r >= 0; r--) begin
      int cells = 0;
      for (int c = 0; c < COLS; c++) cells += grid[r][c];
      if (cells == COLS) k++;
      else begin
        for (int c = 0; c < COLS; c++) ng[dst][c] = grid[r][c];
        dst--;
      end
    end
    grid = ng;
    m_score = m_score + pts[k];
    if (m_score > 65535) m_score = 65535;
    m_over = 0;
    for (int c = 3; c <= 6; c++) if (grid[0][c] != 0) m_over = 1;
  endtask

  task automatic pulse_clear();
    clear_board = 1'b1;
    @(posedge clk); #1;
    clear_board = 1'b0;
    m_reset();
  endtask

  task automatic chk_idle_state(input string tag);
    chk({tag, "_occ"}, occupied, m_flat());
    chk({tag, "_busy"}, NC'(busy), NC'(0));
    chk({tag, "_del"}, NC'(del_to_dro), NC'(0));
    chk({tag, "_score"}, NC'(score), NC'(m_score));
    chk({tag, "_over"}, NC'(game_over), NC'(m_over));
  endtask

  task automatic do_touch(input int a, input int b, input int c,
                          input int d);
    int bl[4];
    int k, n;
    logic [NC-1:0] prev;
    bl = '{a, b, c, d};
    blk0 = 8'(a); blk1 = 8'(b); blk2 = 8'(c); blk3 = 8'(d);
    touch = 1'b1;
    @(posedge clk); #1;
    touch = 1'b0;
    if (m_over) begin
      prev = m_flat();
      repeat (3) begin
        @(posedge clk); #1;
      end
      chk("over_occ_frozen", occupied, prev);
      chk("over_no_del", NC'(del_to_dro), NC'(0));
      chk("over_busy", NC'(busy), NC'(0));
      chk("over_flag", NC'(game_over), NC'(1));
      return;
    end
    m_lock(bl, k);
    chk("busy_after_touch", NC'(busy), NC'(1));
    n = 0;
    while (del_to_dro !== 1'b1 && n < 60) begin
      @(posedge clk); #1;
      n++;
    end
    // Cycles from the touch cycle to the del_to_dro cycle.
    chk("latency", NC'(n + 1), NC'(ROWS + k + 1));
    chk("occ_at_done", occupied, m_flat());
    chk("busy_in_done", NC'(busy), NC'(1));
    @(posedge clk); #1;
    chk("del_single", NC'(del_to_dro), NC'(0));
    chk("lines", NC'(lines_cleared), NC'(k));
    chk("score", NC'(score), NC'(m_score));
    chk("game_over", NC'(game_over), NC'(m_over));
    chk("busy_after", NC'(busy), NC'(0));
    chk("occ_after", occupied, m_flat());
  endtask

  initial begin
    logic [NC-1:0] exp6;
    int dels;
    m_reset();
    repeat (2) @(posedge clk);
    #1;
    chk_idle_state("reset");
    chk("reset_lines", NC'(lines_cleared), NC'(0));
    rst = 1'b0;

    // 1: plain lock, no rows removed
    do_touch(190, 191, 192, 193);
    chk("t1_bits", occupied, NC'(4'hF) << 190);

    // 2: complete row 19
    do_touch(194, 195, 194, 195);
    do_touch(196, 197, 198, 199);
    chk("t2_empty", occupied, NC'(0));
    chk("t2_score", NC'(score), NC'(100));

    // 3: four rows at once with a vertical I
    for (int r = 16; r <= 19; r++) begin
      do_touch(r*10, r*10+1, r*10+2, r*10+3);
      do_touch(r*10+4, r*10+5, r*10+6, r*10+7);
      do_touch(r*10+8, r*10+8, 255, 255);
    end
    do_touch(169, 179, 189, 199);
    chk("t3_lines", NC'(lines_cleared), NC'(4));
    chk("t3_score", NC'(score), NC'(900));
    chk("t3_empty", occupied, NC'(0));

    // 6: rows 17 and 19 removed, row 18 drops to 19
    do_touch(190, 191, 192, 193);
    do_touch(194, 195, 196, 197);
    do_touch(198, 180, 181, 255);
    do_touch(170, 171, 172, 173);
    do_touch(174, 175, 176, 177);
    do_touch(178, 185, 255, 255);
    do_touch(179, 199, 255, 179);
    exp6 = '0;
    exp6[190] = 1'b1; exp6[191] = 1'b1; exp6[195] = 1'b1;
    chk("t6_occ", occupied, exp6);
    chk("t6_score", NC'(score), NC'(1200));

    // 5: re-touch while busy, then wipe mid-scan
    blk0 = 8'd100; blk1 = 8'd101; blk2 = 8'd102; blk3 = 8'd103;
    touch = 1'b1;
    @(posedge clk); #1;
    touch = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    blk0 = 8'd50; blk1 = 8'd51; blk2 = 8'd52; blk3 = 8'd53;
    touch = 1'b1;
    @(posedge clk); #1;
    touch = 1'b0;
    chk("t5_retouch_dropped", occupied,
        exp6 | (NC'(4'hF) << 100));
    @(posedge clk); #1;
    pulse_clear();
    dels = 0;
    repeat (30) begin
      if (del_to_dro !== 1'b0) dels++;
      @(posedge clk); #1;
    end
    chk("t5_no_del", NC'(dels), NC'(0));
    chk_idle_state("t5");
    do_touch(0, 1, 2, 10);

    // 4: lock into the spawn area
    pulse_clear();
    do_touch(4, 14, 24, 5);
    chk("t4_over", NC'(game_over), NC'(1));
    do_touch(190, 191, 192, 193);
    pulse_clear();
    chk_idle_state("t4_cleared");

    // random locks biased to the lower rows
    for (int t = 0; t < 60; t++) begin
      int p[4];
      foreach (p[i])
        p[i] = ($urandom_range(0, 99) < 5) ?
               200 + int'($urandom_range(0, 55)) :
               int'($urandom_range(120, 199));
      repeat ($urandom_range(0, 3)) @(posedge clk);
      #1;
      do_touch(p[0], p[1], p[2], p[3]);
      if (m_over) pulse_clear();
    end

    // rst mid-scan aborts without a spawn pulse
    do_touch(30, 31, 32, 33);
    blk0 = 8'd150; blk1 = 8'd151; blk2 = 8'd152; blk3 = 8'd153;
    touch = 1'b1;
    @(posedge clk); #1;
    touch = 1'b0;
    repeat (5) @(posedge clk);
    #1;
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    m_reset();
    dels = 0;
    repeat (30) begin
      if (del_to_dro !== 1'b0) dels++;
      @(posedge clk); #1;
    end
    chk("rst_no_del", NC'(dels), NC'(0));
    chk_idle_state("rst_mid");
    chk("rst_lines", NC'(lines_cleared), NC'(0));

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_asrt, n_fail);
    $finish;
  end

endmodule
